cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit.sv | 192 +++++++++++++++++++
 tb/tb_cp0_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS-style coprocessor-0 register file.
// It holds the exception state (Status, Cause, EPC, BadVAddr), the interrupt
// request logic and, optionally, the Count/Compare timer.
// Optional feature: define CP0_TIMER_EN to build the Count/Compare timer.
// Without the macro, Count and Compare read 0, writes to them are ignored,
// and the timer interrupt is tied low.
module cp0_unit #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          COUNT_DIV    = 1,
  parameter logic [31:0] RESET_STATUS = 32'h1000FF01
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_req_o,
  output logic                  timer_int_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;

  // Status bits software can change: CU0, IM[7:0], EXL, IE.
  localparam logic [31:0] STATUS_MASK  = 32'h1000_FF03;

  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_ADES     = 5'd5;

  logic [31:0]           status_q;
  logic [31:0]           epc_q;
  logic [31:0]           badvaddr_q;
  logic                  cause_bd_q;
  logic [4:0]            cause_exc_q;
  logic [1:0]            cause_ipsw_q;
  logic [NUM_HW_INT-1:0] ip_hw_q;
  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic                  timer_q;

  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        status_exl;
  logic        status_ie;
  logic [7:0]  status_im;
  logic [5:0]  hw_pad;
  logic [7:0]  cause_ip;
  logic [31:0] cause_val;

  assign wr_status  = we_i && (waddr_i == REG_STATUS);
  assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc     = we_i && (waddr_i == REG_EPC);

  assign status_exl = status_q[1];
  assign status_ie  = status_q[0];
  assign status_im  = status_q[15:8];

  // Status: mtc0 first, then exception/eret override EXL (last assignment wins).
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= RESET_STATUS & STATUS_MASK;
    end else begin
      if (wr_status) status_q <= wdata_i & STATUS_MASK;
      if (exc_valid_i)  status_q[1] <= 1'b1;
      else if (eret_i)  status_q[1] <= 1'b0;
    end
  end

  // EPC: the first-level exception overrides a same-cycle mtc0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc_q <= '0;
    end else begin
      if (wr_epc) epc_q <= wdata_i;
      if (exc_valid_i && !status_exl)
        epc_q <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
    end
  end

  // Cause: software IP bits from mtc0, BD/ExcCode from exceptions, hw lines sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_bd_q   <= 1'b0;
      cause_exc_q  <= '0;
      cause_ipsw_q <= '0;
      ip_hw_q      <= '0;
    end else begin
      ip_hw_q <= hw_int_i;
      if (wr_cause) cause_ipsw_q <= wdata_i[9:8];
      if (exc_valid_i) begin
        cause_exc_q <= exc_code_i;
        if (!status_exl) cause_bd_q <= exc_bd_i;
      end
    end
  end

  // BadVAddr: captured only on address-error exceptions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      badvaddr_q <= '0;
    end else if (exc_valid_i && (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES)) begin
      badvaddr_q <= exc_badvaddr_i;
    end
  end

`ifdef CP0_TIMER_EN
  logic        div_q;
  logic        count_tick;
  logic [31:0] count_d;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);
  assign count_tick = (COUNT_DIV == 2) ? div_q : 1'b1;

  // Next Count value: mtc0 load, else increment on divider tick (wraps naturally).
  // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (wr_count)        count_d = wdata_i;
    else if (count_tick) count_d = count_q + 32'd1;
  end

  // Timer state: divider phase, Count, Compare and the sticky match flag.
  // The flag looks at the value Count is about to take, so it rises on the
  // same edge Count reaches Compare; a Compare write clears it and wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      div_q   <= (wr_count || COUNT_DIV != 2) ? 1'b0 : ~div_q;
      count_q <= count_d;
      if (wr_compare) compare_q <= wdata_i;
      if (wr_compare)                timer_q <= 1'b0;
      else if (count_d == compare_q) timer_q <= 1'b1;
    end
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign timer_q   = 1'b0;
`endif

  // Assemble Cause.IP: [1:0] software, [2+i] hardware, [7] also the timer.
  assign hw_pad    = 6'(ip_hw_q);
  assign cause_ip  = {hw_pad[5] | timer_q, hw_pad[4:0], cause_ipsw_q};
  assign cause_val = {cause_bd_q, 15'b0, cause_ip, 1'b0, cause_exc_q, 2'b00};

  // Read mux: combinational, shows pre-write values during an mtc0 cycle.
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_q;
      REG_COMPARE:  rdata_o = compare_q;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause_val;
      REG_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_val;
  assign epc_o       = epc_q;
  assign int_req_o   = (|(cause_ip & status_im)) & status_ie & ~status_exl;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: table-driven mtc0/mfc0 vectors plus hand-written sequences for
// timer, interrupts, exceptions, priorities and reset, with read expectations
// queued in a scoreboard and compared when the read is performed.
module tb_cp0_unit;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        int_req;
  logic        timer_int;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_unit u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .we_i           (we),
    .waddr_i        (waddr),
    .wdata_i        (wdata),
    .raddr_i        (raddr),
    .rdata_o        (rdata),
    .hw_int_i       (hw_int),
    .exc_valid_i    (exc_valid),
    .exc_code_i     (exc_code),
    .exc_pc_i       (exc_pc),
    .exc_bd_i       (exc_bd),
    .exc_badvaddr_i (exc_badvaddr),
    .eret_i         (eret),
    .status_o       (status),
    .cause_o        (cause),
    .epc_o          (epc),
    .int_req_o      (int_req),
    .timer_int_o    (timer_int)
  );

`ifdef CP0_TIMER_EN
  logic        we2;
  logic [31:0] rdata2;
  logic [31:0] status2;
  logic [31:0] cause2;
  logic [31:0] epc2;
  logic        int_req2;
  logic        timer_int2;

  cp0_unit #(.COUNT_DIV(2)) u_div2 (
    .clk            (clk),
    .reset_n        (reset_n),
    .we_i           (we2),
    .waddr_i        (5'd9),
    .wdata_i        (32'd10),
    .raddr_i        (5'd9),
    .rdata_o        (rdata2),
    .hw_int_i       (6'b0),
    .exc_valid_i    (1'b0),
    .exc_code_i     (5'd0),
    .exc_pc_i       (32'd0),
    .exc_bd_i       (1'b0),
    .exc_badvaddr_i (32'd0),
    .eret_i         (1'b0),
    .status_o       (status2),
    .cause_o        (cause2),
    .epc_o          (epc2),
    .int_req_o      (int_req2),
    .timer_int_o    (timer_int2)
  );
`endif

  typedef struct {
    string       name;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [4:0] ra, input logic [31:0] exp);
    exp_t e;
    e.name  = name;
    e.raddr = ra;
    e.exp   = exp;
    exp_q.push_back(e);
  endtask

  // Perform the queued mfc0 reads and compare against the scoreboard.
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      raddr = e.raddr;
      #1;
      check(e.name, rdata, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_bd = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    idle_inputs();
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bva, input logic with_exc, input logic with_eret);
    @(negedge clk);
    exc_valid = with_exc; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badvaddr = bva; eret = with_eret;
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    logic [31:0] div2_exp[5];

    reset_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; hw_int = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr = '0; eret = 1'b0;
`ifdef CP0_TIMER_EN
    we2 = 1'b0;
`endif

    // ---------------- reset state ----------------
    #12;
    push_exp("rst_status",   5'd12, 32'h1000FF01);
    push_exp("rst_count",    5'd9,  32'h0);
    push_exp("rst_compare",  5'd11, 32'h0);
    push_exp("rst_cause",    5'd13, 32'h0);
    push_exp("rst_epc",      5'd14, 32'h0);
    push_exp("rst_badvaddr", 5'd8,  32'h0);
    drain();
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_timer",   {31'b0, timer_int}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_int_req", {31'b0, int_req}, 32'h0);
    check("post_rst_status_o", status, 32'h1000FF01);

    // ---------------- table-driven mtc0/mfc0 ----------------
    vecs[0]  = '{5'd12, 32'hFFFFFFFF, 5'd12, 32'h1000FF03};
    vecs[1]  = '{5'd12, 32'h00000000, 5'd12, 32'h00000000};
    vecs[2]  = '{5'd13, 32'hFFFFFFFF, 5'd13, 32'h00000300};
    vecs[3]  = '{5'd13, 32'h00000000, 5'd13, 32'h00000000};
    vecs[4]  = '{5'd14, 32'h12345678, 5'd14, 32'h12345678};
    vecs[5]  = '{5'd8,  32'hFFFFFFFF, 5'd8,  32'h00000000};
    vecs[6]  = '{5'd3,  32'hFFFFFFFF, 5'd3,  32'h00000000};
    vecs[7]  = '{5'd11, 32'h00000055, 5'd11, TIMER ? 32'h00000055 : 32'h0};
    vecs[8]  = '{5'd9,  32'h00001000, 5'd9,  TIMER ? 32'h00001000 : 32'h0};
    vecs[9]  = '{5'd12, 32'h1000FF01, 5'd12, 32'h1000FF01};
    vecs[10] = '{5'd31, 32'hFFFFFFFF, 5'd31, 32'h00000000};
    for (int i = 0; i < 11; i++) begin
      mtc0(vecs[i].waddr, vecs[i].wdata);
      push_exp($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      drain();
    end

    // ---------------- same-cycle write is not bypassed ----------------
    @(negedge clk);
    we = 1'b1; waddr = 5'd14; wdata = 32'h00005555; raddr = 5'd14;
    #1;
    check("no_bypass_old", rdata, 32'h12345678);
    tick();
    idle_inputs();
    push_exp("no_bypass_new", 5'd14, 32'h00005555);
    drain();

    // ---------------- timer ----------------
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      push_exp($sformatf("timer_count%0d", k), 5'd9, TIMER ? 32'(k) : 32'h0);
      drain();
      check($sformatf("timer_flag%0d", k), {31'b0, timer_int}, {31'b0, TIMER && (k >= 5)});
    end
    push_exp("timer_cause_ip7", 5'd13, TIMER ? 32'h00008000 : 32'h0);
    drain();
    check("timer_int_req", {31'b0, int_req}, {31'b0, TIMER});
    mtc0(5'd11, 32'd20);
    check("timer_clear", {31'b0, timer_int}, 32'h0);
    push_exp("compare20", 5'd11, TIMER ? 32'd20 : 32'h0);
    drain();

    // ---------------- Count wrap ----------------
    mtc0(5'd9, 32'hFFFFFFFF);
    push_exp("wrap_load", 5'd9, TIMER ? 32'hFFFFFFFF : 32'h0);
    drain();
    tick();
    push_exp("wrap_zero", 5'd9, 32'h0);
    drain();
    tick();
    push_exp("wrap_one", 5'd9, TIMER ? 32'h1 : 32'h0);
    drain();
    mtc0(5'd11, 32'h80000000);

    // ---------------- interrupts ----------------
    check("int_idle", {31'b0, int_req}, 32'h0);
    @(negedge clk);
    hw_int = 6'b000001;
    #1;
    check("int_not_yet", {31'b0, int_req}, 32'h0);
    tick();
    check("int_hw0", {31'b0, int_req}, 32'h1);
    push_exp("int_cause_ip2", 5'd13, 32'h00000400);
    drain();
    mtc0(5'd12, 32'h1000FF03);
    check("int_exl_blocks", {31'b0, int_req}, 32'h0);
    mtc0(5'd12, 32'h1000FE01);
    check("int_im_other", {31'b0, int_req}, 32'h1);
    mtc0(5'd12, 32'h1000FB01);
    check("int_im_masked", {31'b0, int_req}, 32'h0);
    mtc0(5'd12, 32'h1000FF00);
    check("int_ie_off", {31'b0, int_req}, 32'h0);
    mtc0(5'd12, 32'h1000FF01);
    @(negedge clk);
    hw_int = 6'b100000;
    tick();
    push_exp("int_cause_ip7_hw", 5'd13, 32'h00008000);
    drain();
    check("int_hw5", {31'b0, int_req}, 32'h1);
    @(negedge clk);
    hw_int = 6'b0;
    tick();
    check("int_cleared", {31'b0, int_req}, 32'h0);
    mtc0(5'd13, 32'h00000200);
    check("int_sw1", {31'b0, int_req}, 32'h1);
    mtc0(5'd13, 32'h0);

    // ---------------- exceptions ----------------
    raise(5'd8, 32'h100, 1'b1, 32'h0, 1'b1, 1'b0);
    push_exp("exc1_epc",    5'd14, 32'h000000FC);
    push_exp("exc1_cause",  5'd13, 32'h80000020);
    push_exp("exc1_status", 5'd12, 32'h1000FF03);
    drain();
    raise(5'd12, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
    push_exp("exc2_epc",   5'd14, 32'h000000FC);
    push_exp("exc2_cause", 5'd13, 32'h80000030);
    drain();
    raise(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("eret1_status", status, 32'h1000FF01);
    raise(5'd4, 32'h300, 1'b0, 32'hDEAD0001, 1'b1, 1'b0);
    push_exp("adel_badvaddr", 5'd8,  32'hDEAD0001);
    push_exp("adel_epc",      5'd14, 32'h00000300);
    push_exp("adel_cause",    5'd13, 32'h00000010);
    drain();
    raise(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    raise(5'd8, 32'h304, 1'b0, 32'h00001234, 1'b1, 1'b0);
    push_exp("sys_badvaddr_hold", 5'd8, 32'hDEAD0001);
    drain();
    raise(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    raise(5'd8, 32'h600, 1'b0, 32'h0, 1'b1, 1'b1);
    check("exc_beats_eret", status, 32'h1000FF03);
    check("exc_eret_epc", epc, 32'h00000600);
    raise(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

    // ---------------- exception/eret vs same-cycle mtc0 ----------------
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h700; exc_bd = 1'b0;
    we = 1'b1; waddr = 5'd14; wdata = 32'h0000AAAA;
    tick();
    idle_inputs();
    check("exc_over_mtc0_epc", epc, 32'h00000700);
    @(negedge clk);
    eret = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'h10000F03;
    tick();
    idle_inputs();
    check("eret_over_mtc0_status", status, 32'h10000F01);
    mtc0(5'd12, 32'h1000FF01);

    // ---------------- reset during an exception ----------------
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h400;
    #1 reset_n = 1'b0;
    #1;
    check("midrst_status", status, 32'h1000FF01);
    check("midrst_epc", epc, 32'h0);
    check("midrst_int_req", {31'b0, int_req}, 32'h0);
    #1;
    reset_n = 1'b1;
    idle_inputs();
    tick();
    check("postrst_epc", epc, 32'h0);
    check("postrst_status", status, 32'h1000FF01);
    check("postrst_cause", cause, 32'h0);

`ifdef CP0_TIMER_EN
    // ---------------- COUNT_DIV = 2 ----------------
    div2_exp[0] = 32'd10; div2_exp[1] = 32'd10; div2_exp[2] = 32'd11;
    div2_exp[3] = 32'd11; div2_exp[4] = 32'd12;
    @(negedge clk);
    we2 = 1'b1;
    tick();
    we2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check($sformatf("div2_count%0d", k), rdata2, div2_exp[k]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
